// File: rtl/subtrator_serial_if.sv
// rtl/subtrator_serial_if.sv - start/done handshake and operand/result bundle for subtrator_serial
// Optional overflow signal is present only with SUBTRATOR_SERIAL_OVF_EN defined.
interface subtrator_serial_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SUBTRATOR_SERIAL_OVF_EN
  logic             overflow;

  modport master (output start, a, b, input busy, done, diff, borrow_out, overflow);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out, overflow);
`else
  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/subtrator_serial.sv
// rtl/subtrator_serial.sv - bit-serial LSB-first subtractor diff = a - b with start/done handshake
// Optional signed overflow flag enabled by defining SUBTRATOR_SERIAL_OVF_EN.
module subtrator_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  subtrator_serial_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             borrow_fin;
  logic             x;
  logic             y;
  logic             d;
  logic             borrow_nxt;
`ifdef SUBTRATOR_SERIAL_OVF_EN
  logic             a_msb;
  logic             b_msb;
  logic             ovf;
`endif

  // Single full-subtractor cell fed by the operand LSBs and the borrow flop
  assign x          = ra[0];
  assign y          = rb[0];
  assign d          = x ^ y ^ borrow;
  assign borrow_nxt = (~x & y) | (~(x ^ y) & borrow);
  assign last       = (cnt == CW'(WIDTH - 1));

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and operand-accept decode; start is only honoured outside CALC
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath: load on accept, shift one bit per CALC cycle, capture flags on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra         <= '0;
      rb         <= '0;
      res        <= '0;
      cnt        <= '0;
      borrow     <= 1'b0;
      borrow_fin <= 1'b0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else if (accept) begin
      ra     <= bus.a;
      rb     <= bus.b;
      cnt    <= '0;
      borrow <= 1'b0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
      a_msb  <= bus.a[WIDTH-1];
      b_msb  <= bus.b[WIDTH-1];
`endif
    end else if (state == CALC) begin
      ra     <= ra >> 1;
      rb     <= rb >> 1;
      res    <= {d, res[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      borrow <= borrow_nxt;
      if (last) begin
        borrow_fin <= borrow_nxt;
`ifdef SUBTRATOR_SERIAL_OVF_EN
        // d is the result MSB being shifted in on this final cycle
        ovf        <= (a_msb != b_msb) & (d != a_msb);
`endif
      end
    end
  end

  assign bus.busy       = (state == CALC);
  assign bus.done       = (state == DONE);
  assign bus.diff       = res;
  assign bus.borrow_out = borrow_fin;
`ifdef SUBTRATOR_SERIAL_OVF_EN
  assign bus.overflow   = ovf;
`endif

endmodule

// File: tb/tb_subtrator_serial.sv
// tb/tb_subtrator_serial.sv - scoreboard bench for subtrator_serial at WIDTH=8 and WIDTH=4
module tb_subtrator_serial;

  typedef struct {
    int unsigned diff;
    logic        bo;
    logic        ov;
    int          k;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q8[$];
  exp_t q4[$];
  logic prev_done8 = 1'b0;
  logic prev_done4 = 1'b0;

  subtrator_serial_if #(.WIDTH(8)) d8 ();
  subtrator_serial_if #(.WIDTH(4)) d4 ();

  subtrator_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(d8));
  subtrator_serial #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(d4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and two's-complement values
  function automatic exp_t model(input int w, input int unsigned a, input int unsigned b, input int k);
    exp_t e;
    int   sa;
    int   sb;
    int   r;
    sa = (a >= (1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
    sb = (b >= (1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
    r  = sa - sb;
    e.diff = (a + (1 << w) - b) % (1 << w);
    e.bo   = (a < b);
    e.ov   = (r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1);
    e.k    = k;
    return e;
  endfunction

  // Monitor for the 8-bit instance: compare each done pulse against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (d8.done && d8.busy) check("w8_done_with_busy", 1, 0);
      if (d8.done && prev_done8) check("w8_done_width", 2, 1);
      if (d8.done) begin
        if (q8.size() == 0) check("w8_unexpected_done", 1, 0);
        else begin
          e = q8.pop_front();
          check("w8_diff", d8.diff, e.diff);
          check("w8_borrow_out", d8.borrow_out, e.bo);
          check("w8_latency", cyc - e.k, 8);
`ifdef SUBTRATOR_SERIAL_OVF_EN
          check("w8_overflow", d8.overflow, e.ov);
`endif
        end
      end
    end
    prev_done8 <= d8.done;
  end

  // Monitor for the 4-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (d4.done && d4.busy) check("w4_done_with_busy", 1, 0);
      if (d4.done && prev_done4) check("w4_done_width", 2, 1);
      if (d4.done) begin
        if (q4.size() == 0) check("w4_unexpected_done", 1, 0);
        else begin
          e = q4.pop_front();
          check("w4_diff", d4.diff, e.diff);
          check("w4_borrow_out", d4.borrow_out, e.bo);
          check("w4_latency", cyc - e.k, 4);
`ifdef SUBTRATOR_SERIAL_OVF_EN
          check("w4_overflow", d4.overflow, e.ov);
`endif
        end
      end
    end
    prev_done4 <= d4.done;
  end

  task automatic wait_free8();
    int n = 0;
    @(negedge clk);
    while (d8.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("w8_busy_timeout", 1, 0);
  endtask

  task automatic issue8(input int unsigned a, input int unsigned b);
    wait_free8();
    d8.a = 8'(a);
    d8.b = 8'(b);
    d8.start = 1'b1;
    q8.push_back(model(8, a, b, cyc + 1));
    @(posedge clk);
    #1 d8.start = 1'b0;
  endtask

  task automatic issue4(input int unsigned a, input int unsigned b);
    int n = 0;
    @(negedge clk);
    while (d4.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("w4_busy_timeout", 1, 0);
    d4.a = 4'(a);
    d4.b = 4'(b);
    d4.start = 1'b1;
    q4.push_back(model(4, a, b, cyc + 1));
    @(posedge clk);
    #1 d4.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy8"}, d8.busy, 0);
    check({tag, "_done8"}, d8.done, 0);
    check({tag, "_diff8"}, d8.diff, 0);
    check({tag, "_bo8"}, d8.borrow_out, 0);
    check({tag, "_busy4"}, d4.busy, 0);
    check({tag, "_diff4"}, d4.diff, 0);
`ifdef SUBTRATOR_SERIAL_OVF_EN
    check({tag, "_ovf8"}, d8.overflow, 0);
`endif
  endtask

  initial begin
    int n;
    d8.start = 1'b0; d8.a = '0; d8.b = '0;
    d4.start = 1'b0; d4.a = '0; d4.b = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Directed cases: basic, underflow, zero, signed overflow corners
    issue8(5, 3);
    issue8(3, 5);
    issue8(0, 0);
    issue8(128, 1);
    issue8(127, 255);
    drain();

    // Held start: operand change during CALC is ignored, second result reloads in DONE
    wait_free8();
    d8.a = 8'd200; d8.b = 8'd100; d8.start = 1'b1;
    q8.push_back(model(8, 200, 100, cyc + 1));
    @(negedge clk);
    @(negedge clk);
    d8.a = 8'd10; d8.b = 8'd20;
    n = 0;
    while (!d8.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check("b2b_done_timeout", 1, 0);
    q8.push_back(model(8, 10, 20, cyc + 1));
    @(posedge clk);
    #1 d8.start = 1'b0;
    drain();

    // Reset during CALC cycle 3: outputs clear at once and the op never completes
    issue8(9, 4);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("midreset");
    q8.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue8(9, 4);
    drain();

    // Random 8-bit operands
    for (int i = 0; i < 40; i++) issue8($urandom_range(255), $urandom_range(255));
    drain();

    // Exhaustive 4-bit sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        issue4(a, b);
    drain();

    check("q8_empty", q8.size(), 0);
    check("q4_empty", q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
